// File: rtl/mux_n_pkg.sv
// Shared constants and helpers for the N-channel registered mux.
// Round-robin search is used only when MUX_N_REG_ROUND_ROBIN_EN is defined.
package mux_n_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_N     = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // First set bit of req[n-1:0] at or above start, wrapping modulo n.
  function automatic logic [3:0] rr_next(
    input logic [15:0] req,
    input logic [3:0]  start,
    input int          n
  );
    logic [3:0] g;
    logic       found;
    int         idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      idx = (int'(start) + k) % n;
      if (k < n && !found && req[idx]) begin
        g     = 4'(idx);
        found = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/mux_n_reg_if.sv
// Producer/consumer bundle for mux_n_reg.
// slave is the mux side, master the environment side.
interface mux_n_reg_if
  import mux_n_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N
);

  localparam int SEL_W = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SEL_W-1:0]   sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic [SEL_W-1:0]   out_chan;
  logic               out_ready;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    input  sel,
    output out_data,
    output out_valid,
    output out_chan,
    input  out_ready
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    output sel,
    input  out_data,
    input  out_valid,
    input  out_chan,
    output out_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant with a pointer to the last served channel.
// Pointer moves only when the grant is consumed (advance).
module rr_arbiter
  import mux_n_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [SEL_W-1:0] grant,
  output logic             grant_valid
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] start;

  assign start = (ptr == SEL_W'(N - 1)) ? '0 : ptr + 1'b1;
  assign grant = SEL_W'(rr_next(16'(req), 4'(start), N));
  assign grant_valid = |req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= SEL_W'(N - 1);
    end else if (advance) begin
      ptr <= grant;
    end
  end

endmodule

// File: rtl/mux_n_reg.sv
// N-channel registered mux with valid/ready on both sides.
// MUX_N_REG_ROUND_ROBIN_EN: round-robin grant instead of sel.
module mux_n_reg
  import mux_n_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N
) (
  input logic         clk,
  input logic         rst,
  mux_n_reg_if.slave  bus
);

  localparam int SEL_W = $clog2(N);

  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             load;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] chan_q;
  out_state_e       state;

`ifdef MUX_N_REG_ROUND_ROBIN_EN
  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (bus.in_valid),
    .advance     (load),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  logic unused_sel;
  assign unused_sel = ^bus.sel;
`else
  // Padding to 2**SEL_W makes out-of-range sel see no valid.
  logic [(1<<SEL_W)-1:0] valid_pad;

  always_comb begin
    valid_pad        = '0;
    valid_pad[N-1:0] = bus.in_valid;
  end

  assign grant       = bus.sel;
  assign grant_valid = valid_pad[bus.sel];
`endif

  assign load = !rst && grant_valid &&
                (state == EMPTY || bus.out_ready);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SEL_W'(i)) begin
        sel_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (load && grant == SEL_W'(i)) begin
        bus.in_ready[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      data_q <= '0;
      chan_q <= '0;
    end else if (load) begin
      state  <= FULL;
      data_q <= sel_data;
      chan_q <= grant;
    end else if (bus.out_ready) begin
      state  <= EMPTY;
    end
  end

  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;

endmodule

// File: tb/tb_mux_n_reg.sv
// Directed bench for mux_n_reg: N=4 and N=3 instances.
// Follows MUX_N_REG_ROUND_ROBIN_EN to pick expectations.
module tb_mux_n_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mux_n_reg_if #(.WIDTH(16), .N(4)) b4 ();
  mux_n_reg_if #(.WIDTH(16), .N(3)) b3 ();

  mux_n_reg #(.WIDTH(16), .N(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  mux_n_reg #(.WIDTH(16), .N(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_d [4];
  int          rr_seq [6];

  initial begin
    exp_d  = '{16'h0001, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    rr_seq = '{0, 1, 3, 0, 1, 3};

    b4.in_data   = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'h0001};
    b4.in_valid  = 4'hF;
    b4.sel       = '0;
    b4.out_ready = 1'b1;
    b3.in_data   = {16'h3333, 16'h2222, 16'h1111};
    b3.in_valid  = 3'b111;
    b3.sel       = '0;
    b3.out_ready = 1'b1;

    tick();
    tick();
    check("rst_valid", 32'(b4.out_valid), 32'h0);
    check("rst_data", 32'(b4.out_data), 32'h0);
    check("rst_chan", 32'(b4.out_chan), 32'h0);
    check("rst_ready", 32'(b4.in_ready), 32'h0);
    check("rst_ready3", 32'(b3.in_ready), 32'h0);
    b3.in_valid = 3'b000;
    rst = 1'b0;

    // all channels valid: fixed sel 0..3, RR from ptr=3 also 0..3
    for (int s = 0; s < 4; s++) begin
      b4.sel = 2'(s);
      #1;
      check("seq_ready", 32'(b4.in_ready), 32'(1 << s));
      tick();
      check("seq_valid", 32'(b4.out_valid), 32'h1);
      check("seq_data", 32'(b4.out_data), 32'(exp_d[s]));
      check("seq_chan", 32'(b4.out_chan), 32'(s));
    end

    b4.in_data  = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'h00FF};
    b4.in_valid = 4'b0001;
    b4.sel      = 2'd0;
    tick();
    check("bp_load", 32'(b4.out_data), 32'h00FF);
    b4.out_ready = 1'b0;
    b4.in_valid  = 4'hF;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_ready", 32'(b4.in_ready), 32'h0);
      tick();
      check("bp_data", 32'(b4.out_data), 32'h00FF);
      check("bp_valid", 32'(b4.out_valid), 32'h1);
    end
    b4.in_valid  = 4'h0;
    b4.out_ready = 1'b1;
    tick();
    check("drain_valid", 32'(b4.out_valid), 32'h0);
    check("drain_hold", 32'(b4.out_data), 32'h00FF);
    check("drain_chan", 32'(b4.out_chan), 32'h0);

`ifndef MUX_N_REG_ROUND_ROBIN_EN
    b3.sel      = 2'd3;
    b3.in_valid = 3'b111;
    #1;
    check("oor_ready", 32'(b3.in_ready), 32'h0);
    tick();
    check("oor_valid", 32'(b3.out_valid), 32'h0);
    b3.sel = 2'd2;
    #1;
    check("n3_ready", 32'(b3.in_ready), 32'h4);
    tick();
    check("n3_data", 32'(b3.out_data), 32'h3333);
    check("n3_chan", 32'(b3.out_chan), 32'h2);
    b3.in_valid = 3'b000;
`endif

    // hold F0F0 under back-pressure, then reset between edges
    b4.in_data   = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hF0F0};
    b4.in_valid  = 4'b0001;
    b4.sel       = 2'd0;
    b4.out_ready = 1'b0;
    tick();
    check("mid_hold", 32'(b4.out_data), 32'hF0F0);
    b4.in_valid = 4'h0;
    #2;
    rst = 1'b1;
    #1;
    check("mid_valid", 32'(b4.out_valid), 32'h0);
    check("mid_data", 32'(b4.out_data), 32'h0);
    tick();
    rst = 1'b0;
    b4.in_data   = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'h0001};
    b4.out_ready = 1'b1;

`ifdef MUX_N_REG_ROUND_ROBIN_EN
    b4.in_valid = 4'b1011;
    b4.sel      = 2'd2;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_ready", 32'(b4.in_ready), 32'(1 << rr_seq[k]));
      tick();
      check("rr_chan", 32'(b4.out_chan), 32'(rr_seq[k]));
      check("rr_data", 32'(b4.out_data), 32'(exp_d[rr_seq[k]]));
    end
`else
    b4.in_valid = 4'hF;
    b4.sel      = 2'd2;
    tick();
    check("post_chan", 32'(b4.out_chan), 32'h2);
    check("post_data", 32'(b4.out_data), 32'hCCCC);
    check("post_valid", 32'(b4.out_valid), 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
